layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised, pipelined pixel compositor for the VGA path. Successor to the fixed two-sprite colour mapper.
- Merges NUM_LAYERS keyed sprite/graphics layers over a background using fixed priority, with layer 0 on top.
- Accumulates pairwise per-frame overlap (collision) flags.
- Applies a frame-stepped global fade-out/fade-in for screen transitions.
- Sits between the sprite/graphics ROM readers and the VGA DAC outputs.

Parameters:
- NUM_LAYERS, 4, number of keyed layers (2..8).
- COLOR_W, 4, bits per colour channel.
- KEY_COLOR, 12'h0E0, transparency key {R,G,B}, 3*COLOR_W bits.
- KEY_EN, 4'b1111, per-layer key enable; bit i applies to layer i.
- FADE_DIV, 2, frames per fade step (>=1).

Ports:
- pixel_Clk  in  1  pixel clock.
- Reset  in  1  asynchronous, active-low reset.
- blank  in  1  1 = active video, 0 = blanking.
- frame_start  in  1  one-cycle pulse at first pixel of frame.
- layer_on  in  NUM_LAYERS  per-layer coverage at current pixel.
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  layer i occupies [i*3*COLOR_W +: 3*COLOR_W], ordered {R,G,B}.
- bg_rgb  in  3*COLOR_W  background colour, always opaque.
- fade_cmd  in  2  00 none, 01 fade out, 10 fade in, 11 none.
- Red, Green, Blue  out  COLOR_W each  composited, faded pixel.
- coll_flags  out  NUM_LAYERS*(NUM_LAYERS-1)/2  overlap flags latched for the previous frame.
- fade_busy  out  1  high while fading.
- fade_level  out  COLOR_W+1  current brightness, 0..2^COLOR_W.

Behaviour:
- Reset (asynchronous, Reset=0):
  - all pipeline registers 0; Red/Green/Blue=0; coll_flags=0; collision accumulator=0.
  - FSM=BRIGHT; fade_level=2^COLOR_W; fade_busy=0; frame divider=0.
- Stage 1 (registered): opaque[i] = layer_on[i] & ~(KEY_EN[i] & (rgb_i == KEY_COLOR)). Stage 1 also registers all layer colours, bg_rgb and blank.
- Stage 2 (registered):
  - sel = lowest-index opaque layer; if none are opaque, use bg_rgb.
  - Each channel out = (c * fade_level) >> COLOR_W. The product is 2*COLOR_W+1 bits, truncated with no rounding.
  - Level 2^COLOR_W passes the colour through unchanged; level 0 gives black.
  - If the stage-2 blank input is 0, outputs are 0.
- Latency: exactly 2 pixel_Clk cycles from inputs to Red/Green/Blue. No stalls.
- Collision:
  - Pair index order is (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
  - Each cycle, accum[p] |= opaque[a] & opaque[b] & blank, all from stage 1.
  - On the cycle frame_start is seen at stage 1 (one cycle after the input pulse):
    - coll_flags <= accum OR'd with that cycle's hits; accum <= 0.
    - That cycle's hits go to the closing frame only.
  - coll_flags holds its value for the whole next frame.
- Fade FSM. States: BRIGHT, FADE_OUT, DARK, FADE_IN.
  - fade_cmd is sampled every cycle.
  - BRIGHT + 01 -> FADE_OUT. DARK + 10 -> FADE_IN. All other commands are ignored, including during a fade.
  - A step occurs on a frame_start input pulse when the divider reaches FADE_DIV-1; the divider then resets to 0.
  - The divider is cleared on entry to FADE_OUT/FADE_IN.
  - FADE_OUT: on each step, level -= 1. When level reaches 0 -> DARK.
  - FADE_IN: on each step, level += 1. When level reaches 2^COLOR_W -> BRIGHT.
  - fade_busy = 1 in FADE_OUT/FADE_IN only.
  - If a command and frame_start arrive in the same cycle, the transition happens and the step waits for a later frame.
- Reset mid-frame or mid-fade: immediate return to reset values. The first frame after reset reports coll_flags=0.

Test Plan:
- Priority/key, N=4, COLOR_W=4, level 16:
  - layer_on=0110, layer1=0x0E0, layer2=0x3A5 -> output 0x3A5 two cycles later (layer1 keyed out).
  - layer_on=0000 -> output bg_rgb.
  - blank=0 -> output 0x000.
- Latency: drive a distinct colour each cycle -> every output matches the input from exactly 2 cycles earlier; no bubbles.
- Collision:
  - Layers 0 and 3 are opaque together for one active pixel in frame k -> after the frame_start ending frame k, coll_flags=6'b000100 (pair 2 = (0,3)). It holds through frame k+1 and clears after frame k+1 if no overlap.
  - Same overlap during blank=0 -> flags stay 0.
- Fade out, FADE_DIV=2:
  - fade_cmd=01 in BRIGHT -> level 16→15 after 2 frame_starts, reaches 0 after 32; then DARK, fade_busy=0, outputs 0x000.
  - Colour 0xF84 at level 8 -> output 0x742.
- Fade in from DARK: fade_cmd=10 -> level increments every 2 frames to 16, then BRIGHT. fade_cmd=01 issued mid-fade is ignored.
- Async reset: assert Reset=0 mid-fade with coll_flags nonzero -> immediately level=16, FSM=BRIGHT, coll_flags=0, RGB=0, no pixel_Clk edge required.

Source files
------------

// File: rtl/layer_compositor.sv
// Pixel compositor: merges NUM_LAYERS keyed layers over an opaque background.
// Layer 0 has the highest priority. The block also accumulates pairwise overlap
// flags for each frame and applies a frame-stepped global fade.
// Latency is 2 pixel_Clk cycles from inputs to Red/Green/Blue. There are no stalls.
// Ports:
//   pixel_Clk/Reset      : pixel clock, async active-low reset
//   blank, frame_start   : active-video qualifier, first-pixel pulse
//   layer_on/layer_rgb   : per-layer coverage and {R,G,B} colour
//   bg_rgb, fade_cmd     : background colour, fade command (01 out, 10 in)
//   Red/Green/Blue       : composited, faded pixel
//   coll_flags           : pair overlap flags of the previous frame
//   fade_busy/fade_level : fade status and current brightness
module layer_compositor #(
  parameter int                    NUM_LAYERS = 4,
  parameter int                    COLOR_W    = 4,
  parameter logic [3*COLOR_W-1:0]  KEY_COLOR  = 12'h0E0,
  parameter logic [NUM_LAYERS-1:0] KEY_EN     = 4'b1111,
  parameter int                    FADE_DIV   = 2
) (
  input  logic                                    pixel_Clk,
  input  logic                                    Reset,
  input  logic                                    blank,
  input  logic                                    frame_start,
  input  logic [NUM_LAYERS-1:0]                   layer_on,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]         layer_rgb,
  input  logic [3*COLOR_W-1:0]                    bg_rgb,
  input  logic [1:0]                              fade_cmd,
  output logic [COLOR_W-1:0]                      Red,
  output logic [COLOR_W-1:0]                      Green,
  output logic [COLOR_W-1:0]                      Blue,
  output logic [NUM_LAYERS*(NUM_LAYERS-1)/2-1:0]  coll_flags,
  output logic                                    fade_busy,
  output logic [COLOR_W:0]                        fade_level
);

  localparam int PW    = 3*COLOR_W;
  localparam int NP    = NUM_LAYERS*(NUM_LAYERS-1)/2;
  localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [COLOR_W:0] LVL_FULL = {1'b1, {COLOR_W{1'b0}}};
  localparam logic [COLOR_W:0] LVL_ONE  = {{COLOR_W{1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV-1);

  typedef enum logic [1:0] {BRIGHT, FADE_OUT, DARK, FADE_IN} fade_state_t;

  // ---------------- stage 1: key test and input capture ----------------
  logic [NUM_LAYERS-1:0]    opaque_d, s1_opaque_q;
  logic [NUM_LAYERS*PW-1:0] s1_rgb_q;
  logic [PW-1:0]            s1_bg_q;
  logic                     s1_blank_q, s1_fs_q;

  always_comb begin
    opaque_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      opaque_d[i] = layer_on[i] & ~(KEY_EN[i] & (layer_rgb[i*PW +: PW] == KEY_COLOR));
  end

  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      s1_opaque_q <= '0;
      s1_rgb_q    <= '0;
      s1_bg_q     <= '0;
      s1_blank_q  <= 1'b0;
      s1_fs_q     <= 1'b0;
    end else begin
      s1_opaque_q <= opaque_d;
      s1_rgb_q    <= layer_rgb;
      s1_bg_q     <= bg_rgb;
      s1_blank_q  <= blank;
      s1_fs_q     <= frame_start;
    end
  end

  // ---------------- collision accumulation ----------------
  // Pairs are packed in the order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
  logic [NP-1:0] hits, accum_q, coll_q;

  for (genvar a = 0; a < NUM_LAYERS-1; a++) begin : g_pa
    for (genvar b = a+1; b < NUM_LAYERS; b++) begin : g_pb
      localparam int P = a*(2*NUM_LAYERS-a-1)/2 + (b-a-1);
      assign hits[P] = s1_opaque_q[a] & s1_opaque_q[b] & s1_blank_q;
    end
  end

  // Hits seen in the frame_start cycle still belong to the frame that is closing.
  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      accum_q <= '0;
      coll_q  <= '0;
    end else if (s1_fs_q) begin
      coll_q  <= accum_q | hits;
      accum_q <= '0;
    end else begin
      accum_q <= accum_q | hits;
    end
  end

  // ---------------- fade FSM ----------------
  fade_state_t      state_q, state_d;
  logic [COLOR_W:0] level_q, level_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_now;

  assign step_now = frame_start & (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    div_d   = div_q;
    unique case (state_q)
      BRIGHT: if (fade_cmd == 2'b01) begin
        state_d = FADE_OUT;
        div_d   = '0;
      end
      DARK: if (fade_cmd == 2'b10) begin
        state_d = FADE_IN;
        div_d   = '0;
      end
      FADE_OUT: if (frame_start) begin
        if (step_now) begin
          div_d   = '0;
          level_d = level_q - LVL_ONE;
          if (level_q == LVL_ONE) state_d = DARK;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      FADE_IN: if (frame_start) begin
        if (step_now) begin
          div_d   = '0;
          level_d = level_q + LVL_ONE;
          if (level_q == LVL_FULL - LVL_ONE) state_d = BRIGHT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = BRIGHT;
    endcase
  end

  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= BRIGHT;
      level_q <= LVL_FULL;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      div_q   <= div_d;
    end
  end

  // ---------------- stage 2: priority select and fade scaling ----------------
  logic [PW-1:0] sel_rgb, rgb_d, rgb_q;

  // The product keeps the full 2*COLOR_W+1 bits and is truncated after the shift.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [COLOR_W:0]   lvl);
    logic [2*COLOR_W:0] prod;
    prod = (2*COLOR_W+1)'(c) * (2*COLOR_W+1)'(lvl);
    return COLOR_W'(prod >> COLOR_W);
  endfunction

  // Scan from the bottom layer upward so that the lowest-index opaque layer wins.
  always_comb begin
    sel_rgb = s1_bg_q;
    for (int i = NUM_LAYERS-1; i >= 0; i--)
      if (s1_opaque_q[i]) sel_rgb = s1_rgb_q[i*PW +: PW];
  end

  always_comb begin
    rgb_d = '0;
    if (s1_blank_q)
      rgb_d = {scale(sel_rgb[2*COLOR_W +: COLOR_W], level_q),
               scale(sel_rgb[COLOR_W +: COLOR_W], level_q),
               scale(sel_rgb[0 +: COLOR_W], level_q)};
  end

  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

  assign Red        = rgb_q[2*COLOR_W +: COLOR_W];
  assign Green      = rgb_q[COLOR_W +: COLOR_W];
  assign Blue       = rgb_q[0 +: COLOR_W];
  assign coll_flags = coll_q;
  assign fade_busy  = (state_q == FADE_OUT) || (state_q == FADE_IN);
  assign fade_level = level_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed testbench for layer_compositor with the default parameters
// (4 layers, 4-bit colour, key 0x0E0, two frames per fade step).
// Each feature task drives its own stimulus and checks against hand-computed values.
module tb_layer_compositor;
  localparam int N  = 4;
  localparam int PW = 12;

  logic            pixel_Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            blank = 1'b0;
  logic            frame_start = 1'b0;
  logic [N-1:0]    layer_on = '0;
  logic [N*PW-1:0] layer_rgb = '0;
  logic [PW-1:0]   bg_rgb = '0;
  logic [1:0]      fade_cmd = 2'b00;
  logic [3:0]      Red, Green, Blue;
  logic [5:0]      coll_flags;
  logic            fade_busy;
  logic [4:0]      fade_level;
  logic [11:0]     rgb;

  int checks = 0;
  int failures = 0;

  assign rgb = {Red, Green, Blue};

  layer_compositor dut (
    .pixel_Clk(pixel_Clk), .Reset(Reset), .blank(blank), .frame_start(frame_start),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .fade_cmd(fade_cmd),
    .Red(Red), .Green(Green), .Blue(Blue), .coll_flags(coll_flags),
    .fade_busy(fade_busy), .fade_level(fade_level)
  );

  always #5 pixel_Clk = ~pixel_Clk;

  task automatic step();
    @(posedge pixel_Clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    #2;
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb got %h exp %h", rgb, 12'h000); end
    checks++; if (coll_flags !== 6'b0) begin failures++; $display("FAIL reset_coll got %b exp %b", coll_flags, 6'b0); end
    checks++; if (fade_level !== 5'd16) begin failures++; $display("FAIL reset_level got %0d exp %0d", fade_level, 16); end
    checks++; if (fade_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp %b", fade_busy, 1'b0); end
    step();
    step();
    Reset = 1'b1;
    step();
  endtask

  task automatic test_priority();
    layer_rgb[0*PW +: PW] = 12'h111;
    layer_rgb[1*PW +: PW] = 12'h0E0;
    layer_rgb[2*PW +: PW] = 12'h3A5;
    layer_rgb[3*PW +: PW] = 12'h777;
    bg_rgb = 12'h246;
    blank  = 1'b1;
    layer_on = 4'b0110; step(); step();
    checks++; if (rgb !== 12'h3A5) begin failures++; $display("FAIL prio_keyed_l1 got %h exp %h", rgb, 12'h3A5); end
    layer_on = 4'b0000; step(); step();
    checks++; if (rgb !== 12'h246) begin failures++; $display("FAIL prio_bg got %h exp %h", rgb, 12'h246); end
    layer_on = 4'b1000; step(); step();
    checks++; if (rgb !== 12'h777) begin failures++; $display("FAIL prio_l3 got %h exp %h", rgb, 12'h777); end
    layer_on = 4'b0101; step(); step();
    checks++; if (rgb !== 12'h111) begin failures++; $display("FAIL prio_l0_top got %h exp %h", rgb, 12'h111); end
    layer_on = 4'b0010; step(); step();
    checks++; if (rgb !== 12'h246) begin failures++; $display("FAIL prio_key_only got %h exp %h", rgb, 12'h246); end
    blank = 1'b0; layer_on = 4'b0110; step(); step();
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL prio_blank got %h exp %h", rgb, 12'h000); end
    blank = 1'b1; layer_on = 4'b0000;
    step(); step();
  endtask

  task automatic test_latency();
    logic [11:0] c, prev;
    prev = 12'h000;
    layer_on = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      c = 12'h100 + 12'(k * 17);
      layer_rgb[0*PW +: PW] = c;
      step();
      if (k > 0) begin
        checks++;
        if (rgb !== prev) begin failures++; $display("FAIL latency_k%0d got %h exp %h", k, rgb, prev); end
      end
      prev = c;
    end
    layer_on = 4'b0000;
    layer_rgb[0*PW +: PW] = 12'h111;
    step(); step();
  endtask

  task automatic test_collision();
    layer_on = 4'b0000;
    blank = 1'b1;
    pulse_fs();
    pulse_fs();
    checks++; if (coll_flags !== 6'b000000) begin failures++; $display("FAIL coll_clean got %b exp %b", coll_flags, 6'b0); end
    // frame k: layers 0 and 3 overlap for one active pixel
    layer_on = 4'b1001; step();
    layer_on = 4'b0000; step(); step();
    checks++; if (coll_flags !== 6'b000000) begin failures++; $display("FAIL coll_midframe got %b exp %b", coll_flags, 6'b0); end
    pulse_fs();
    checks++; if (coll_flags !== 6'b000100) begin failures++; $display("FAIL coll_pair03 got %b exp %b", coll_flags, 6'b000100); end
    step(); step(); step();
    checks++; if (coll_flags !== 6'b000100) begin failures++; $display("FAIL coll_hold got %b exp %b", coll_flags, 6'b000100); end
    pulse_fs();
    checks++; if (coll_flags !== 6'b000000) begin failures++; $display("FAIL coll_clear got %b exp %b", coll_flags, 6'b0); end
    // overlap during blanking is not counted
    blank = 1'b0; layer_on = 4'b1001; step();
    layer_on = 4'b0000; blank = 1'b1;
    pulse_fs();
    checks++; if (coll_flags !== 6'b000000) begin failures++; $display("FAIL coll_blanked got %b exp %b", coll_flags, 6'b0); end
    // overlap in the frame_start cycle itself goes to the closing frame: layers 1,2 (pair 3)
    layer_rgb[1*PW +: PW] = 12'h555;
    layer_on = 4'b0110; frame_start = 1'b1; step();
    layer_on = 4'b0000; frame_start = 1'b0; step();
    checks++; if (coll_flags !== 6'b001000) begin failures++; $display("FAIL coll_fs_cycle got %b exp %b", coll_flags, 6'b001000); end
    pulse_fs();
    checks++; if (coll_flags !== 6'b000000) begin failures++; $display("FAIL coll_fs_not_carried got %b exp %b", coll_flags, 6'b0); end
    layer_rgb[1*PW +: PW] = 12'h0E0;
  endtask

  task automatic test_fade_out();
    layer_on = 4'b0000; blank = 1'b1; bg_rgb = 12'hF84;
    fade_cmd = 2'b01; step(); fade_cmd = 2'b00;
    checks++; if (fade_busy !== 1'b1) begin failures++; $display("FAIL fo_busy got %b exp %b", fade_busy, 1'b1); end
    pulse_fs();
    checks++; if (fade_level !== 5'd16) begin failures++; $display("FAIL fo_after1 got %0d exp %0d", fade_level, 16); end
    pulse_fs();
    checks++; if (fade_level !== 5'd15) begin failures++; $display("FAIL fo_after2 got %0d exp %0d", fade_level, 15); end
    for (int p = 3; p <= 16; p++) pulse_fs();
    checks++; if (fade_level !== 5'd8) begin failures++; $display("FAIL fo_after16 got %0d exp %0d", fade_level, 8); end
    step(); step();
    checks++; if (rgb !== 12'h742) begin failures++; $display("FAIL fo_scale_l8 got %h exp %h", rgb, 12'h742); end
    for (int p = 17; p <= 31; p++) pulse_fs();
    checks++; if (fade_level !== 5'd1 || fade_busy !== 1'b1) begin failures++; $display("FAIL fo_after31 got lvl=%0d busy=%b exp lvl=1 busy=1", fade_level, fade_busy); end
    pulse_fs();
    checks++; if (fade_level !== 5'd0 || fade_busy !== 1'b0) begin failures++; $display("FAIL fo_dark got lvl=%0d busy=%b exp lvl=0 busy=0", fade_level, fade_busy); end
    step(); step();
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL fo_black got %h exp %h", rgb, 12'h000); end
  endtask

  task automatic test_fade_in();
    // command and frame_start together: transition now, stepping starts later
    fade_cmd = 2'b10; frame_start = 1'b1; step();
    fade_cmd = 2'b00; frame_start = 1'b0; step();
    checks++; if (fade_busy !== 1'b1 || fade_level !== 5'd0) begin failures++; $display("FAIL fi_enter got lvl=%0d busy=%b exp lvl=0 busy=1", fade_level, fade_busy); end
    pulse_fs();
    checks++; if (fade_level !== 5'd0) begin failures++; $display("FAIL fi_after1 got %0d exp %0d", fade_level, 0); end
    pulse_fs();
    checks++; if (fade_level !== 5'd1) begin failures++; $display("FAIL fi_after2 got %0d exp %0d", fade_level, 1); end
    fade_cmd = 2'b01; step(); fade_cmd = 2'b00;
    for (int p = 3; p <= 4; p++) pulse_fs();
    checks++; if (fade_level !== 5'd2 || fade_busy !== 1'b1) begin failures++; $display("FAIL fi_ignore_cmd got lvl=%0d busy=%b exp lvl=2 busy=1", fade_level, fade_busy); end
    for (int p = 5; p <= 31; p++) pulse_fs();
    checks++; if (fade_level !== 5'd15 || fade_busy !== 1'b1) begin failures++; $display("FAIL fi_after31 got lvl=%0d busy=%b exp lvl=15 busy=1", fade_level, fade_busy); end
    pulse_fs();
    checks++; if (fade_level !== 5'd16 || fade_busy !== 1'b0) begin failures++; $display("FAIL fi_bright got lvl=%0d busy=%b exp lvl=16 busy=0", fade_level, fade_busy); end
    step(); step();
    checks++; if (rgb !== 12'hF84) begin failures++; $display("FAIL fi_full got %h exp %h", rgb, 12'hF84); end
    fade_cmd = 2'b10; step(); fade_cmd = 2'b00; step();
    checks++; if (fade_busy !== 1'b0) begin failures++; $display("FAIL fi_cmd_in_bright got %b exp %b", fade_busy, 1'b0); end
  endtask

  task automatic test_async_reset();
    bg_rgb = 12'hFFF; layer_on = 4'b0000; blank = 1'b1;
    fade_cmd = 2'b01; step(); fade_cmd = 2'b00;
    pulse_fs(); pulse_fs();
    layer_on = 4'b1001; step(); layer_on = 4'b0000;
    pulse_fs();
    step(); step();
    checks++; if (coll_flags !== 6'b000100 || fade_level !== 5'd15) begin failures++; $display("FAIL ar_pre got coll=%b lvl=%0d exp coll=000100 lvl=15", coll_flags, fade_level); end
    checks++; if (rgb !== 12'hEEE) begin failures++; $display("FAIL ar_pre_rgb got %h exp %h", rgb, 12'hEEE); end
    // assert reset between clock edges; outputs must clear without an edge
    #2 Reset = 1'b0;
    #1;
    checks++; if (fade_level !== 5'd16 || fade_busy !== 1'b0) begin failures++; $display("FAIL ar_fade got lvl=%0d busy=%b exp lvl=16 busy=0", fade_level, fade_busy); end
    checks++; if (coll_flags !== 6'b0 || rgb !== 12'h000) begin failures++; $display("FAIL ar_out got coll=%b rgb=%h exp coll=000000 rgb=000", coll_flags, rgb); end
    step();
    Reset = 1'b1;
    layer_on = 4'b1001; step(); layer_on = 4'b0000;
    step(); step();
    checks++; if (coll_flags !== 6'b0) begin failures++; $display("FAIL ar_first_frame got %b exp %b", coll_flags, 6'b0); end
    checks++; if (rgb !== 12'hFFF) begin failures++; $display("FAIL ar_rgb_after got %h exp %h", rgb, 12'hFFF); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_latency();
    test_collision();
    test_fade_out();
    test_fade_in();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
